// File: rtl/lc3_memaccess_pkg.sv
// Shared definitions for the LC3 data-memory access controller:
// opcode constants, FSM state encoding and memory-op decode.
package lc3_memaccess_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        ACC
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        STORE
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [3:0] opcode);
        mem_op_t op;
        case (opcode)
            OP_LD, OP_LDR, OP_LDI: op = LOAD;
            OP_ST, OP_STR, OP_STI: op = STORE;
            default:               op = NONE;
        endcase
        return op;
    endfunction

    function automatic logic is_indirect_opcode(input logic [3:0] opcode);
        return (opcode == OP_LDI) || (opcode == OP_STI);
    endfunction

endpackage

// File: rtl/lc3_memaccess_ctrl.sv
// LC3 data-memory access controller: performs direct and indirect
// loads/stores for the execute stage and returns load data to writeback.
module lc3_memaccess_ctrl
    import lc3_memaccess_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_execute,
    input  logic [DATA_W-1:0] IR_exec,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] M_data,
    input  logic              Mem_control_out,
    input  logic [REG_W-1:0]  dr,
    input  logic [DATA_W-1:0] Data_dout,
    output logic [DATA_W-1:0] Data_addr,
    output logic [DATA_W-1:0] Data_din,
    output logic              Data_rd,
    output logic              Data_we,
    output logic              mem_busy,
    output logic [DATA_W-1:0] memout,
    output logic              memout_valid,
    output logic [REG_W-1:0]  dr_out,
    output logic              protocol_err
);

    state_t              state;
    logic                cur_load;
    logic [REG_W-1:0]    dr_hold;
    logic [DATA_W-1:0]   store_data;

    logic [3:0]          opcode;
    mem_op_t             op;
    logic                presented;
    logic                accept;
    logic                mismatch;
    logic                unused_ir_bits;

    assign opcode         = IR_exec[DATA_W-1:DATA_W-4];
    assign op             = decode_op(opcode);
    assign presented      = enable_execute && (op != NONE);
    assign accept         = presented && !mem_busy;
    assign mismatch       = Mem_control_out != is_indirect_opcode(opcode);
    assign unused_ir_bits = ^IR_exec[DATA_W-5:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cur_load     <= 1'b0;
            dr_hold      <= '0;
            store_data   <= '0;
            Data_addr    <= '0;
            Data_din     <= '0;
            Data_rd      <= 1'b0;
            Data_we      <= 1'b0;
            mem_busy     <= 1'b0;
            memout       <= '0;
            memout_valid <= 1'b0;
            dr_out       <= '0;
            protocol_err <= 1'b0;
        end else begin
            memout_valid <= 1'b0;

            if (presented && mem_busy) begin
                protocol_err <= 1'b1;
            end

            // Final-access load data is captured regardless of what follows
            if (state == ACC && cur_load) begin
                memout       <= Data_dout;
                memout_valid <= 1'b1;
                dr_out       <= dr_hold;
            end

            if (accept) begin
                if (mismatch) begin
                    protocol_err <= 1'b1;
                end
                Data_addr <= aluout;
                cur_load  <= (op == LOAD);
                dr_hold   <= dr;
                if (Mem_control_out) begin
                    state      <= PTR;
                    Data_rd    <= 1'b1;
                    Data_we    <= 1'b0;
                    mem_busy   <= 1'b1;
                    store_data <= M_data;
                end else begin
                    state    <= ACC;
                    Data_rd  <= (op == LOAD);
                    Data_we  <= (op == STORE);
                    mem_busy <= 1'b0;
                    if (op == STORE) begin
                        Data_din <= M_data;
                    end
                end
            end else if (state == PTR) begin
                // Pointer read completes: the fetched word becomes the final address
                state     <= ACC;
                Data_addr <= Data_dout;
                Data_rd   <= cur_load;
                Data_we   <= !cur_load;
                mem_busy  <= 1'b0;
                if (!cur_load) begin
                    Data_din <= store_data;
                end
            end else begin
                state    <= IDLE;
                Data_rd  <= 1'b0;
                Data_we  <= 1'b0;
                mem_busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lc3_memaccess_ctrl.md
Name: lc3_memaccess_ctrl

Overview:
- Consumer (receiving end) of the execute_out bus. Takes the execute stage's memory-type instructions and performs the LC3 data-memory accesses.
- Covers direct loads/stores (LD, LDR, ST, STR) and two-access indirect ops (LDI, STI).
- Returns load data plus destination register to writeback, and raises a stall to the upstream stage during indirect ops.
- Sits between the execute stage and the data memory, which has asynchronous read and synchronous write.

Parameters:
- DATA_W, 16, width of data, address and IR.
- REG_W, 3, width of register specifier.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable_execute  input  1  execute output valid this cycle.
- IR_exec  input  16  instruction; opcode is IR_exec[15:12].
- aluout  input  16  effective address from execute.
- M_data  input  16  store data from execute.
- Mem_control_out  input  1  1 = indirect access, 0 = direct.
- dr  input  3  destination register of the load.
- Data_dout  input  16  memory read data, combinational from Data_addr.
- Data_addr  output  16  memory address (registered).
- Data_din  output  16  memory write data (registered).
- Data_rd  output  1  read strobe.
- Data_we  output  1  write strobe; memory writes on the clock edge ending this cycle.
- mem_busy  output  1  upstream must not present a new memory op this cycle.
- memout  output  16  load result.
- memout_valid  output  1  one-cycle pulse; memout and dr_out are valid.
- dr_out  output  3  destination register accompanying memout.
- protocol_err  output  1  sticky violation flag.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0. Strobes drop immediately, so an in-flight write is abandoned and never completes.
- Opcode classes:
  - LD=0010, LDR=0110, LDI=1010 are loads.
  - ST=0011, STR=0111, STI=1011 are stores.
  - All other opcodes are ignored and cause no state change.
- Indirect selection: indirect iff Mem_control_out=1. A mismatch between Mem_control_out and the opcode class (e.g. LDI with Mem_control_out=0) sets protocol_err; the op proceeds per Mem_control_out.
- Accept rule: op accepted in cycle T when enable_execute=1, opcode is a memory class, and mem_busy=0.
- States:
  - IDLE: no access.
  - PTR: indirect pointer read.
  - ACC: final access.
- Direct op accepted at T:
  - T+1: state ACC, Data_addr=aluout.
  - Load: Data_rd=1; Data_dout captured at end of T+1; memout_valid=1 with memout and dr_out at T+2.
  - Store: Data_we=1 and Data_din=M_data for T+1 only.
- Indirect op accepted at T:
  - T+1: state PTR, Data_addr=aluout, Data_rd=1, mem_busy=1; pointer captured at end of T+1.
  - T+2: state ACC, Data_addr=pointer.
  - LDI: Data_rd=1; memout_valid at T+3.
  - STI: Data_we=1, Data_din=M_data (captured at T).
- Back-to-back: an op accepted while in ACC enters its first access cycle directly, with no IDLE bubble. Direct ops therefore sustain one per cycle.
- Stall violation: an op presented while mem_busy=1 is dropped and protocol_err is set. protocol_err clears only on reset.
- Idle outputs: outside ACC/PTR, Data_rd=Data_we=0. Data_addr and Data_din hold their last values. memout holds its last value; memout_valid=0.
- Data_rd and Data_we are never both 1.
- Address arithmetic: none; addresses pass through unmodified, with full 16-bit range and no wrap handling.

Decomposition:
- Shared package lc3_memaccess_pkg holds:
  - the opcode constants;
  - the state enum (IDLE, PTR, ACC);
  - the mem_op_t enum (NONE, LOAD, STORE);
  - a decode function mapping IR_exec[15:12] to mem_op_t.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- LD, aluout=0x3005, Data_dout=0xBEEF, dr=3 -> Data_rd=1 with addr 0x3005 at T+1; memout=0xBEEF, dr_out=3, memout_valid at T+2.
- STR, aluout=0x4000, M_data=0x1234 -> Data_we=1, Data_addr=0x4000, Data_din=0x1234 at T+1 only; no memout_valid.
- LDI, aluout=0x3010, mem[0x3010]=0x5000, mem[0x5000]=0x00AA -> mem_busy at T+1; addr 0x5000 at T+2; memout=0x00AA at T+3.
- STI, aluout=0x3020, mem[0x3020]=0x6000, M_data=0x7777 -> Data_we at T+2 with Data_addr=0x6000, Data_din=0x7777.
- LDI followed by LD presented at T+1 -> LD dropped, protocol_err=1 until reset; LDI still completes.
- STI with reset asserted during T+2 -> Data_we falls immediately, mem[0x6000] unchanged, all outputs 0.
